// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor controller.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LAST,
    DONE
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit serial full adder with its carry flop and MSB carry-in capture.
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic clr,
  input  logic set,
  input  logic en,
  input  logic cap,
  output logic s,
  output logic co,
  output logic c_msb
);

  logic c;

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      c <= 1'b0;
    else if (clr) c <= 1'b0;
    else if (set) c <= 1'b1;
    else if (en)  c <= co;
  end

  // carry into the MSB, kept for the signed-overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      c_msb <= 1'b0;
    else if (cap) c_msb <= c;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add (and subtract when SERIAL_ADD_SUB_EN is defined) controller driving two PISO registers.
// state | meaning
// IDLE  | waiting for start
// LOAD  | ld strobe to both PISOs; clear counter, sum register and carry
// SHIFT | WIDTH cycles of sh_en; serial bits arrive one cycle after each
// LAST  | consume the MSB, no shift
// DONE  | one-cycle done pulse with result held on sum/cout/ovf
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             ld,
  output logic             sh_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sum_sr;
  logic            bit_valid;
  logic            sub_q;
  logic            s, co, c_msb;

`ifdef SERIAL_ADD_SUB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          sub_q <= 1'b0;
    else if (state == IDLE && start)  sub_q <= sub;
  end
`else
  assign sub_q = 1'b0;
`endif

  serial_fa_cell u_fa (
    .clk   (clk),
    .rst   (rst),
    .a     (a_bit),
    .b     (b_bit ^ sub_q),
    .clr   ((state == LOAD) && !sub_q),
    .set   ((state == LOAD) && sub_q),
    .en    (bit_valid),
    .cap   (state == LAST),
    .s     (s),
    .co    (co),
    .c_msb (c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ld    <= 1'b0;
      sh_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          ld    <= 1'b1;
          busy  <= 1'b1;
        end
        LOAD: begin
          state <= SHIFT;
          ld    <= 1'b0;
          sh_en <= 1'b1;
          cnt   <= '0;
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= LAST;
            sh_en <= 1'b0;
          end
        end
        LAST: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // PISO outputs lag sh_en by one edge, so the adder works one cycle behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_valid <= 1'b0;
      sum_sr    <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      bit_valid <= sh_en;
      if (state == LOAD)  sum_sr <= '0;
      else if (bit_valid) sum_sr <= {s, sum_sr[WIDTH-1:1]};
      if (state == LAST) begin
        sum  <= {s, sum_sr[WIDTH-1:1]};
        cout <= co;
      end
    end
  end

  assign ovf = c_msb ^ cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl with PISO models and an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic sub = 1'b0;
`endif
  logic a_bit = 1'b0, b_bit = 1'b0;
  logic ld, sh_en, busy, done, cout, ovf;
  logic [W-1:0] sum;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .a_bit(a_bit), .b_bit(b_bit), .ld(ld), .sh_en(sh_en), .busy(busy),
    .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int a, input int b, input int s,
                                output int rs, output int rc, output int ro);
    int half, sa, sb, sr;
    half = 1 << (W - 1);
    sa = (a >= half) ? a - (1 << W) : a;
    sb = (b >= half) ? b - (1 << W) : b;
    if (s != 0) begin
      rs = (a - b) & ((1 << W) - 1);
      rc = (a >= b) ? 1 : 0;
      sr = sa - sb;
    end else begin
      rs = (a + b) & ((1 << W) - 1);
      rc = ((a + b) >= (1 << W)) ? 1 : 0;
      sr = sa + sb;
    end
    ro = (sr < -half || sr > half - 1) ? 1 : 0;
  endfunction

  // operand queues feed the PISOs at ld; expected results are queued per accepted op
  int qa[$], qb[$], qs[$];
  int es[$], ec[$], eo[$];
  int ld_cnt = 0;
  logic [W-1:0] sra = '0, srb = '0;

  always @(posedge clk) begin
    int a, b, s, rs, rc, ro;
    if (ld) begin
      ld_cnt++;
      check("ld_has_operands", qa.size() > 0, 1);
      a = 0; b = 0; s = 0;
      if (qa.size() > 0) begin
        a = qa.pop_front(); b = qb.pop_front(); s = qs.pop_front();
      end
      sra <= a[W-1:0];
      srb <= b[W-1:0];
      model(a, b, s, rs, rc, ro);
      es.push_back(rs); ec.push_back(rc); eo.push_back(ro);
    end else if (sh_en) begin
      a_bit <= sra[0];
      b_bit <= srb[0];
      sra   <= sra >> 1;
      srb   <= srb >> 1;
    end
  end

  always @(posedge rst) begin
    es.delete(); ec.delete(); eo.delete();
    qa.delete(); qb.delete(); qs.delete();
  end

  int done_cnt = 0, last_done = -1;
  bit b2b_mode = 0;
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      check("busy_in_done", busy, 1);
      check("done_has_result", es.size() > 0, 1);
      if (es.size() > 0) begin
        check("sum", sum, es.pop_front());
        check("cout", cout, ec.pop_front());
        check("ovf", ovf, eo.pop_front());
      end
      if (b2b_mode && last_done >= 0) check("b2b_spacing", cyc - last_done, W + 4);
      last_done = cyc;
    end
  end

  task automatic do_op(input int a, input int b, input int s);
    int t0, lat;
    qa.push_back(a); qb.push_back(b); qs.push_back(s);
    start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = s[0];
`endif
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    check("latency", lat, W + 3);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, l0, k, s, mask;
    mask = (1 << W) - 1;
    repeat (2) @(negedge clk);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ld", ld, 0);
    check("rst_sh_en", sh_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_op(8'hFF, 8'h01, 0);
    do_op(8'h7F, 8'h01, 0);
`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h05, 8'h03, 1);
    do_op(8'h03, 8'h05, 1);
`endif
    for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      s = $urandom_range(0, 1);
`else
      s = 0;
`endif
      do_op($urandom_range(0, mask), $urandom_range(0, mask), s);
    end

    // start pulse during SHIFT must be ignored
    d0 = done_cnt; l0 = ld_cnt;
    qa.push_back(8'h5A); qb.push_back(8'hC3); qs.push_back(0);
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_in_shift", sh_en, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * W + 8) @(negedge clk);
    check("ign_done_cnt", done_cnt - d0, 1);
    check("ign_ld_cnt", ld_cnt - l0, 1);

    // reset in the 4th SHIFT cycle aborts with no done
    qa.push_back(8'hAA); qb.push_back(8'h77); qs.push_back(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_in_shift", sh_en, 1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    check("abort_ld", ld, 0);
    check("abort_sh_en", sh_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 6) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    do_op(8'h12, 8'h34, 0);

    // start held high: back-to-back ops
    l0 = ld_cnt;
    for (int i = 0; i < 4; i++) begin
      qa.push_back($urandom_range(0, mask));
      qb.push_back($urandom_range(0, mask));
      qs.push_back(0);
    end
    b2b_mode = 1; last_done = -1;
    start = 1'b1;
    k = 0;
    for (int i = 0; i < 200 && k < 4; i++) begin
      @(negedge clk);
      if (done) k++;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    b2b_mode = 0;
    check("b2b_done_cnt", k, 4);
    check("b2b_ld_cnt", ld_cnt - l0, 4);
    check("b2b_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
